// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the byte-wide memory controller.
//   state_t   - controller FSM state encoding
//   LANE_BITS - number of byte-address bits that select a lane in a word
//   WORD_W    - SRAM word width in bits
package mem_ctrl_pkg;

    localparam int unsigned LANE_BITS = 2;
    localparam int unsigned WORD_W    = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        WR_COMMIT,
        RESP
    } state_t;

endpackage

// File: rtl/byte_lane.sv
// byte_lane: combinational little-endian lane extract and lane merge.
//   word   - 32-bit source word
//   lane   - lane select (lane k = bits [8k+7:8k])
//   wbyte  - byte to insert into the selected lane
//   rbyte  - selected lane of word
//   merged - word with the selected lane replaced by wbyte
module byte_lane
    import mem_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0]    word,
    input  logic [LANE_BITS-1:0] lane,
    input  logic [7:0]           wbyte,
    output logic [7:0]           rbyte,
    output logic [WORD_W-1:0]    merged
);

    // Bit offset of the lane: lane * 8.
    logic [LANE_BITS+2:0] base;

    always_comb begin
        base           = {lane, 3'b000};
        rbyte          = word[base +: 8];
        merged         = word;
        merged[base +: 8] = wbyte;
    end

endmodule

// File: rtl/byte_mem_ctrl.sv
// byte_mem_ctrl: byte-wide processor bus to 32-bit word SRAM controller with a
// one-word line buffer. Writes are read-modify-write on the buffered word.
//   clk, reset           - clock, synchronous active-high reset
//   memread, memwrite    - requests, held until ready (both high = write)
//   adr, writedata       - byte address and write byte
//   memdata              - registered read byte
//   ready                - one-cycle completion pulse
//   sram_en, sram_we     - SRAM access enable / write enable
//   sram_addr            - SRAM word address
//   sram_wdata           - SRAM write word
//   sram_rdata           - SRAM read word, valid the cycle after a read issue
module byte_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = WIDTH - 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [WIDTH-1:0]  adr,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  memdata,
    output logic              ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [AW-1:0]     sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic [WORD_W-1:0] sram_rdata
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    adr_q, adr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [WIDTH-1:0]    memdata_q, memdata_d;
    logic [WORD_W-1:0]   buf_word_q, buf_word_d;
    logic [AW-1:0]       buf_tag_q, buf_tag_d;
    logic                buf_valid_q, buf_valid_d;

    logic [AW-1:0]        in_tag, lat_tag;
    logic                 hit;
    logic [WORD_W-1:0]    lane_word;
    logic [LANE_BITS-1:0] lane_sel;
    logic [7:0]           lane_rbyte;
    logic [WORD_W-1:0]    lane_merged;

    assign in_tag  = AW'(adr >> LANE_BITS);
    assign lat_tag = AW'(adr_q >> LANE_BITS);
    assign hit     = buf_valid_q && (buf_tag_q == in_tag);

    // One lane unit serves three uses: read-hit extract (incoming lane, buffer),
    // miss fill extract (latched lane, SRAM word) and write merge (latched lane, buffer).
    always_comb begin
        lane_word = (state_q == RD_WAIT) ? sram_rdata : buf_word_q;
        lane_sel  = (state_q == IDLE) ? adr[LANE_BITS-1:0] : adr_q[LANE_BITS-1:0];
    end

    byte_lane u_lane (
        .word   (lane_word),
        .lane   (lane_sel),
        .wbyte  (wdata_q[7:0]),
        .rbyte  (lane_rbyte),
        .merged (lane_merged)
    );

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        memdata_d   = memdata_q;
        buf_word_d  = buf_word_q;
        buf_tag_d   = buf_tag_q;
        buf_valid_d = buf_valid_q;
        ready       = 1'b0;
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memwrite) begin
                    adr_d   = adr;
                    wdata_d = writedata;
                    state_d = hit ? WR_COMMIT : WR_ISSUE;
                end else if (memread) begin
                    adr_d   = adr;
                    state_d = hit ? RESP : RD_ISSUE;
                    if (hit) memdata_d = WIDTH'(lane_rbyte);
                end
            end
            RD_ISSUE: begin
                sram_en = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                buf_word_d  = sram_rdata;
                buf_tag_d   = lat_tag;
                buf_valid_d = 1'b1;
                memdata_d   = WIDTH'(lane_rbyte);
                state_d     = RESP;
            end
            WR_ISSUE: begin
                sram_en = 1'b1;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                buf_word_d  = sram_rdata;
                buf_tag_d   = lat_tag;
                buf_valid_d = 1'b1;
                state_d     = WR_COMMIT;
            end
            WR_COMMIT: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                buf_word_d = lane_merged;
                state_d    = RESP;
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sram_addr  = lat_tag;
    assign sram_wdata = lane_merged;
    assign memdata    = memdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            memdata_q   <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            memdata_q   <= memdata_d;
            buf_valid_q <= buf_valid_d;
        end
        adr_q      <= adr_d;
        wdata_q    <= wdata_d;
        buf_word_q <= buf_word_d;
        buf_tag_q  <= buf_tag_d;
    end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// tb_byte_mem_ctrl: directed vector bench for byte_mem_ctrl with a behavioural
// 64-word SRAM and an SRAM activity monitor.
module tb_byte_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite;
    logic [7:0]  adr, writedata;
    logic [7:0]  memdata;
    logic        ready;
    logic        sram_en, sram_we;
    logic [5:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    byte_mem_ctrl #(.WIDTH(8), .AW(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .adr        (adr),
        .writedata  (writedata),
        .memdata    (memdata),
        .ready      (ready),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    logic [31:0] mem [0:63];

    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    end

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [5:0]  last_wa = '0;
    logic [31:0] last_wd = '0;

    always @(negedge clk) begin
        if (sram_en && sram_we) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= sram_addr;
            last_wd <= sram_wdata;
        end else if (sram_en) begin
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          op;      // 0 read, 1 write, 2 both high
        logic [7:0]  a;
        logic [7:0]  d;
        int          lat;
        logic [7:0]  md;
        int          rds;
        int          wrs;
        logic [5:0]  wa;
        logic [31:0] wd;
    } vec_t;

    // Drives one request, returns edges from acceptance to first ready.
    task automatic do_req(input int op, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output int rds, output int wrs);
        int r0, w0;
        @(negedge clk); #1;
        r0 = rd_cnt; w0 = wr_cnt;
        memread   = (op != 1);
        memwrite  = (op != 0);
        adr       = a;
        writedata = d;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk); #1;
            if (ready) break;
        end
        if (!ready) lat = -1;
        @(posedge clk); #1;
        memread  = 1'b0;
        memwrite = 1'b0;
        rds = rd_cnt - r0;
        wrs = wr_cnt - w0;
    endtask

    vec_t vecs [8];

    initial begin
        int lat, rds, wrs, w0;
        vecs[0] = '{0, 8'h06, 8'h00, 3, 8'h33, 1, 0, 6'd0, 32'h0};
        vecs[1] = '{0, 8'h04, 8'h00, 1, 8'h11, 0, 0, 6'd0, 32'h0};
        vecs[2] = '{1, 8'h05, 8'hAA, 2, 8'h11, 0, 1, 6'd1, 32'h4433AA11};
        vecs[3] = '{0, 8'h05, 8'h00, 1, 8'hAA, 0, 0, 6'd0, 32'h0};
        vecs[4] = '{1, 8'h17, 8'h07, 4, 8'hAA, 1, 1, 6'd5, 32'h07000000};
        vecs[5] = '{2, 8'h00, 8'h5C, 4, 8'hAA, 1, 1, 6'd0, 32'hA0B0C05C};
        vecs[6] = '{0, 8'h03, 8'h00, 1, 8'hA0, 0, 0, 6'd0, 32'h0};
        vecs[7] = '{0, 8'h17, 8'h00, 3, 8'h07, 1, 0, 6'd0, 32'h0};

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'hA0B0C0D0;
        mem[1] = 32'h44332211;
        mem[2] = 32'h12345678;
        sram_rdata = '0;
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_memdata", {24'h0, memdata}, 32'h0);
        chk("reset_ready", {31'h0, ready}, 32'h0);
        chk("reset_sram_en", {31'h0, sram_en}, 32'h0);
        chk("reset_sram_we", {31'h0, sram_we}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].op, vecs[i].a, vecs[i].d, lat, rds, wrs);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_memdata", i), {24'h0, memdata}, {24'h0, vecs[i].md});
            chk($sformatf("v%0d_sram_reads", i), rds, vecs[i].rds);
            chk($sformatf("v%0d_sram_writes", i), wrs, vecs[i].wrs);
            if (vecs[i].wrs != 0) begin
                chk($sformatf("v%0d_wr_addr", i), {26'h0, last_wa}, {26'h0, vecs[i].wa});
                chk($sformatf("v%0d_wr_data", i), last_wd, vecs[i].wd);
            end
        end

        // Reset while in WR_WAIT must abort the write before it reaches SRAM.
        @(negedge clk); #1;
        w0 = wr_cnt;
        memwrite = 1'b1; adr = 8'h08; writedata = 8'hFF;
        @(posedge clk);
        @(negedge clk); #1;
        chk("abort_issue_en", {30'h0, sram_en, sram_we}, 32'h2);
        @(posedge clk);
        @(negedge clk); #1;
        chk("abort_wait_en", {31'h0, sram_en}, 32'h0);
        reset = 1'b1; memwrite = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        chk("abort_rst_outs", {29'h0, ready, sram_en, sram_we}, 32'h0);
        chk("abort_memdata", {24'h0, memdata}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_mem2", mem[2], 32'h12345678);
        do_req(0, 8'h08, 8'h00, lat, rds, wrs);
        chk("abort_reread_latency", lat, 3);
        chk("abort_reread_reads", rds, 1);
        chk("abort_reread_memdata", {24'h0, memdata}, 32'h78);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_mem_ctrl.md
BYTE_MEM_CTRL -- requirements
Module: byte_mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: byte-address and data width of the processor-side bus.
REQ-002 SHALL have parameter AW, default WIDTH-2: word-address width of the SRAM port.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port memread, input, 1: read request, held by the initiator until ready.
REQ-006 SHALL have port memwrite, input, 1: write request, held by the initiator until ready.
REQ-007 SHALL have port adr, input, WIDTH: byte address; adr[1:0] selects the lane and adr>>2 selects the word.
REQ-008 SHALL have port writedata, input, WIDTH: write byte.
REQ-009 SHALL have port memdata, output, WIDTH: registered read byte.
REQ-010 SHALL have port ready, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port sram_en, output, 1: SRAM access enable.
REQ-012 SHALL have port sram_we, output, 1: SRAM write enable, qualified by sram_en.
REQ-013 SHALL have port sram_addr, output, AW: SRAM word address.
REQ-014 SHALL have port sram_wdata, output, 32: SRAM write word.
REQ-015 SHALL have port sram_rdata, input, 32: SRAM read word, valid exactly one cycle after a cycle with sram_en=1 and sram_we=0.

Function
REQ-016 SHALL use little-endian lanes for both reads and writes: lane k (adr[1:0]=k) maps to word bits [8k+7:8k].
REQ-017 SHALL implement the states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, WR_COMMIT and RESP.
REQ-018 SHALL accept a request only in IDLE, latching adr, writedata and the operation at the accepting edge; requests in any other state are ignored.
REQ-019 SHALL treat memread and memwrite both high as a write.
REQ-020 SHALL keep a one-word line buffer (word, tag = adr>>2, valid); a hit means valid and tag equal to adr>>2.
REQ-021 On acceptance, SHALL transition: read hit to RESP; read miss to RD_ISSUE; write hit to WR_COMMIT; write miss to WR_ISSUE.
REQ-022 In RD_ISSUE and WR_ISSUE, SHALL drive sram_en=1, sram_we=0 and sram_addr=latched adr>>2.
REQ-023 In RD_WAIT, SHALL load the line buffer with sram_rdata (set valid, set tag), load memdata with the selected lane, and go to RESP.
REQ-024 On a read hit, SHALL load memdata from the selected buffer lane at the acceptance edge.
REQ-025 In WR_WAIT, SHALL load the line buffer from sram_rdata and go to WR_COMMIT.
REQ-026 In WR_COMMIT, SHALL drive sram_en=1, sram_we=1 and sram_wdata=buffer word with the latched lane replaced by the latched byte; it SHALL write the same merged word back into the buffer and go to RESP.
REQ-027 In RESP, SHALL drive ready=1 for exactly one cycle and then return to IDLE; ready SHALL be 0 in all other states.
REQ-028 SHALL meet these latencies, counted in edges from acceptance to the first cycle with ready=1: read hit 1, write hit 2, read miss 3, write miss 4.
REQ-029 The initiator drops its request at the edge after ready; a request still asserted in IDLE SHALL be treated as new.
REQ-030 memdata SHALL hold its value until the next read completes; writes SHALL NOT change memdata.
REQ-031 SHALL drive sram_en=0 and sram_we=0 in IDLE, RD_WAIT, WR_WAIT and RESP.
REQ-032 SHALL perform the SRAM write in a single cycle, so that no partial or multi-cycle write is possible.

Reset
REQ-033 When reset=1 at an edge, SHALL set state to IDLE, memdata to 0 and buffer valid to 0.
REQ-034 Reset SHALL have priority over every transition, including mid-operation; an aborted write SHALL NOT reach the SRAM unless WR_COMMIT was already active before the resetting edge.
REQ-035 During and after reset, combinational outputs SHALL be ready=0, sram_en=0 and sram_we=0.

Structure
REQ-036 SHALL place the state encoding, the LANE_BITS=2 constant and the 32-bit word width constant in shared package mem_ctrl_pkg.
REQ-037 SHALL implement lane extract and lane merge in one combinational sub-module, byte_lane, with inputs word, lane, byte and outputs rbyte, merged.

Verification
REQ-038 Read miss: SRAM word 1 = 32'h44332211, read adr=8'h06 -> sram_en at +1, ready at +3, memdata=8'h33.
REQ-039 Read hit: repeat the read at adr=8'h04 -> no sram_en, ready at +1, memdata=8'h11.
REQ-040 Write hit: write adr=8'h05, data=8'hAA after REQ-038 -> single write to addr 1 with 32'h4433AA11, ready at +2, memdata unchanged.
REQ-041 Write miss: cold buffer, word 5 = 32'h0, write adr=8'h17, data=8'h07 -> read then write of 32'h07000000 to addr 5, ready at +4.
REQ-042 Both memread and memwrite high at adr=8'h00, data=8'h5C -> treated as write, lane 0 = 8'h5C.
REQ-043 Reset asserted in WR_WAIT -> no sram_we pulse, state IDLE, memdata=0, next read of the same word misses.
